// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types for the memory load/store unit: access size
//                encoding, request FSM states, the registered request record
//                and small address helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // Access size encoding as presented by the pipeline; 2'b11 behaves as word.
   typedef enum logic [1:0] {
      SZ_BYTE     = 2'b00,
      SZ_HALF     = 2'b01,
      SZ_WORD     = 2'b10,
      SZ_WORD_ALT = 2'b11
   } lsu_size_e;

   // Request sequencing states.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10
   } lsu_state_e;

   // Request captured at acceptance. wdata holds the lane-replicated store data.
   typedef struct packed {
      logic        op;
      lsu_size_e   size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   localparam logic C_OP_LOAD  = 1'b0;
   localparam logic C_OP_STORE = 1'b1;

   // True when the low address bits are not a multiple of the access size.
   function automatic logic is_misaligned(lsu_size_e size, logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return (off != 2'b00);
      endcase
   endfunction

   // Clears the address bits below the access size.
   function automatic logic [31:0] align_addr(lsu_size_e size, logic [31:0] addr);
      case (size)
         SZ_BYTE: return addr;
         SZ_HALF: return {addr[31:1], 1'b0};
         default: return {addr[31:2], 2'b00};
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu_if
//  Description : Pipeline-side request/response and dcache-side handshake
//                signals of the load/store unit. The misalign response flag
//                exists only when LSU_MISALIGN_EXC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_lsu_if;

   // Pipeline request / response
   logic        req_valid;
   logic        req_op;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
`ifdef LSU_MISALIGN_EXC_EN
   logic        misalign;
`endif

   // Data cache request / response
   logic        dc_valid;
   logic        dc_op;
   logic        dc_uncache;
   logic [7:0]  dc_index;
   logic [19:0] dc_tag;
   logic [3:0]  dc_offset;
   logic [3:0]  dc_wstrb;
   logic [31:0] dc_wdata;
   logic        dc_addr_ok;
   logic        dc_data_ok;
   logic [31:0] dc_rdata;

   // LSU side
   modport slave (
      input  req_valid, req_op, req_size, req_signed, req_addr, req_wdata, flush,
      input  dc_addr_ok, dc_data_ok, dc_rdata,
`ifdef LSU_MISALIGN_EXC_EN
      output misalign,
`endif
      output req_ready, resp_valid, resp_data,
      output dc_valid, dc_op, dc_uncache, dc_index, dc_tag, dc_offset, dc_wstrb, dc_wdata
   );

   // Pipeline plus dcache side
   modport master (
      output req_valid, req_op, req_size, req_signed, req_addr, req_wdata, flush,
      output dc_addr_ok, dc_data_ok, dc_rdata,
`ifdef LSU_MISALIGN_EXC_EN
      input  misalign,
`endif
      input  req_ready, resp_valid, resp_data,
      input  dc_valid, dc_op, dc_uncache, dc_index, dc_tag, dc_offset, dc_wstrb, dc_wdata
   );

endinterface
`default_nettype wire

// File: rtl/mem_lsu_data_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_data_align
//  Description : Combinational lane logic: store byte enables and data
//                replication, and load lane extraction with sign/zero
//                extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_data_align
   import lsu_pkg::*;
(
   input  lsu_size_e   st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata_rep,

   input  lsu_size_e   ld_size,
   input  logic        ld_sgn,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;

   // Store path: enable the addressed lanes and copy the data into every lane.
   always_comb begin
      st_wstrb     = 4'b1111;
      st_wdata_rep = st_wdata;
      case (st_size)
         SZ_BYTE: begin
            st_wstrb     = 4'b0001 << st_off;
            st_wdata_rep = {4{st_wdata[7:0]}};
         end
         SZ_HALF: begin
            st_wstrb     = 4'b0011 << {st_off[1], 1'b0};
            st_wdata_rep = {2{st_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load path: pick the addressed lane and extend it to 32 bits.
   always_comb begin
      w_ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
      w_ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
      ld_data   = ld_rdata;
      case (ld_size)
         SZ_BYTE: ld_data = {{24{ld_sgn & w_ld_byte[7]}}, w_ld_byte};
         SZ_HALF: ld_data = {{16{ld_sgn & w_ld_half[15]}}, w_ld_half};
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lsu
//  Description : Load/store unit between the pipeline MEM stage and the data
//                cache. One request in flight; a flush during a transaction
//                lets the cache access finish but drops the response.
//                Define LSU_MISALIGN_EXC_EN to turn misaligned half/word
//                accesses into a fault response instead of an aligned access.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
   import lsu_pkg::*;
#(
   parameter logic [2:0] UNCACHE_SEG = 3'b101
) (
   input logic      clk,
   input logic      rst,
   mem_lsu_if.slave bus
);

   lsu_state_e  r_state;
   lsu_req_t    r_req;
   logic [3:0]  r_wstrb;
   logic        r_uncache;
   logic        r_cancel;
   logic        r_resp_valid;
   logic [31:0] r_resp_data;

   lsu_size_e   w_size;
   logic [31:0] w_addr;
   logic        w_accept;
   logic        w_mis;
   logic        w_done;
   logic        w_cancel;
   logic [3:0]  w_st_wstrb;
   logic [31:0] w_st_wdata;
   logic [31:0] w_ld_data;

   assign w_size   = lsu_size_e'(bus.req_size);
   assign w_addr   = align_addr(w_size, bus.req_addr);
   assign w_accept = bus.req_valid && (r_state == S_IDLE) && !bus.flush;
   assign w_done   = ((r_state == S_REQ)  && bus.dc_addr_ok && bus.dc_data_ok) ||
                     ((r_state == S_WAIT) && bus.dc_data_ok);
   // A flush coinciding with the completing cycle also drops the response.
   assign w_cancel = r_cancel || bus.flush;

   lsu_data_align u_align (
      .st_size      (w_size),
      .st_off       (w_addr[1:0]),
      .st_wdata     (bus.req_wdata),
      .st_wstrb     (w_st_wstrb),
      .st_wdata_rep (w_st_wdata),
      .ld_size      (r_req.size),
      .ld_sgn       (r_req.sgn),
      .ld_off       (r_req.addr[1:0]),
      .ld_rdata     (bus.dc_rdata),
      .ld_data      (w_ld_data)
   );

   // Request FSM: capture the request, hold the dcache request, collect data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_req        <= '0;
         r_wstrb      <= 4'h0;
         r_uncache    <= 1'b0;
         r_cancel     <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= 32'h0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && !w_mis) begin
                  r_req.op    <= bus.req_op;
                  r_req.size  <= w_size;
                  r_req.sgn   <= bus.req_signed;
                  r_req.addr  <= w_addr;
                  r_req.wdata <= (bus.req_op == C_OP_STORE) ? w_st_wdata : 32'h0;
                  r_wstrb     <= (bus.req_op == C_OP_STORE) ? w_st_wstrb : 4'h0;
                  r_uncache   <= (bus.req_addr[31:29] == UNCACHE_SEG);
                  r_cancel    <= 1'b0;
                  r_state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.flush) begin
                  r_cancel <= 1'b1;
               end
               if (bus.dc_addr_ok) begin
                  r_state <= bus.dc_data_ok ? S_IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.flush) begin
                  r_cancel <= 1'b1;
               end
               if (bus.dc_data_ok) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         // Completion overrides the cancel update above so the flag is clear in IDLE.
         if (w_done) begin
            r_cancel     <= 1'b0;
            r_resp_valid <= !w_cancel;
            r_resp_data  <= (r_req.op == C_OP_STORE) ? 32'h0 : w_ld_data;
         end
      end
   end

`ifdef LSU_MISALIGN_EXC_EN
   logic        r_mis_pend;
   logic [31:0] r_mis_addr;

   assign w_mis = is_misaligned(w_size, bus.req_addr[1:0]);

   // Misaligned fault: no cache access, one-cycle response with the bad address.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mis_pend <= 1'b0;
         r_mis_addr <= 32'h0;
      end else begin
         r_mis_pend <= w_accept && w_mis;
         if (w_accept && w_mis) begin
            r_mis_addr <= bus.req_addr;
         end
      end
   end

   // The fault response can still be squashed by a flush in its own cycle.
   assign bus.misalign   = r_mis_pend && !bus.flush;
   assign bus.resp_valid = r_resp_valid || (r_mis_pend && !bus.flush);
   assign bus.resp_data  = r_mis_pend ? r_mis_addr : r_resp_data;
`else
   // Misaligned accesses proceed with the address bits below the size cleared.
   assign w_mis          = 1'b0;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_data  = r_resp_data;
`endif

   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.dc_valid   = (r_state == S_REQ);
   assign bus.dc_op      = r_req.op;
   assign bus.dc_uncache = r_uncache;
   assign bus.dc_tag     = r_req.addr[31:12];
   assign bus.dc_index   = r_req.addr[11:4];
   assign bus.dc_offset  = r_req.addr[3:0];
   assign bus.dc_wstrb   = r_wstrb;
   assign bus.dc_wdata   = r_req.wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_lsu
//  Description : Self-checking bench for mem_lsu. The driver plays pipeline
//                and data cache, pushes expected responses into a queue, and
//                a monitor pops and compares whenever resp_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

   logic clk = 1'b0;
   logic rst;

   mem_lsu_if bus ();

   mem_lsu #(.UNCACHE_SEG(3'b101)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic logic [31:0] m_align(int size, logic [31:0] a);
      if (size == 1) return a & 32'hFFFF_FFFE;
      if (size >= 2) return a & 32'hFFFF_FFFC;
      return a;
   endfunction

   function automatic logic m_misaligned(int size, logic [31:0] a);
      if (size == 1) return (a % 2) != 0;
      if (size >= 2) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(int size, bit sgn, logic [31:0] a, logic [31:0] rd);
      logic [31:0] v;
      if (size == 0) begin
         v = (rd >> (8 * (a % 4))) & 32'hFF;
         if (sgn && v >= 32'h80) v = v - 32'h100;
      end else if (size == 1) begin
         v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
         if (sgn && v >= 32'h8000) v = v - 32'h10000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_strb(int size, logic [31:0] a);
      if (size == 0) return 32'h1 << (a % 4);
      if (size == 1) return 32'h3 << (a % 4);
      return 32'hF;
   endfunction

   function automatic logic [31:0] m_wdata(int size, logic [31:0] wd);
      if (size == 0) return (wd & 32'hFF) * 32'h0101_0101;
      if (size == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   // ---------------- driver: one transaction, entered just after a negedge ----
   // a_lat: cycles dc_addr_ok stays low; d_lat: cycles from addr_ok to data_ok.
   // flush_k / rst_k: transaction cycle in which flush / reset is driven (-1 none).
   task automatic run_txn(input bit op, input int size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int a_lat, input int d_lat,
                          input int flush_k, input int rst_k);
      logic [31:0] ea;
      int          waited;
      int          total;
      bit          mis;
      exp_t        e;
      ea  = m_align(size, addr);
      mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
      mis = m_misaligned(size, addr);
`endif
      bus.req_valid  = 1'b1;
      bus.req_op     = op;
      bus.req_size   = size[1:0];
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      waited = 0;
      #1;
      while (!bus.req_ready && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk("req_ready_on_issue", 32'(bus.req_ready), 32'h1);
      chk("accept_wait_cycles", 32'(waited), 32'h0);
      if (!bus.req_ready) begin
         bus.req_valid = 1'b0;
         return;
      end
      if (mis) begin
         e.data = addr;
         e.mis  = 1'b1;
         exp_q.push_back(e);
      end else if (flush_k < 0 && rst_k < 0) begin
         e.data = op ? 32'h0 : m_load(size, sgn, ea, rdata);
         e.mis  = 1'b0;
         exp_q.push_back(e);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (mis) begin
         #1;
         chk("mis_no_dc_valid", 32'(bus.dc_valid), 32'h0);
         return;
      end
      total = a_lat + 1 + d_lat;
      for (int k = 0; k < total; k++) begin
         if (k > 0) @(negedge clk);
         bus.flush      = (k == flush_k);
         bus.dc_addr_ok = (k == a_lat);
         bus.dc_data_ok = (k == a_lat + d_lat);
         bus.dc_rdata   = bus.dc_data_ok ? rdata : $urandom();
         rst            = (k == rst_k) ? 1'b0 : 1'b1;
         #1;
         chk("req_ready_busy", 32'(bus.req_ready), 32'h0);
         if (k <= a_lat) begin
            chk("dc_valid_req", 32'(bus.dc_valid), 32'h1);
            chk("dc_op", 32'(bus.dc_op), 32'(op));
            chk("dc_uncache", 32'(bus.dc_uncache), 32'((addr >> 29) == 32'h5));
            chk("dc_tag", 32'(bus.dc_tag), ea >> 12);
            chk("dc_index", 32'(bus.dc_index), (ea >> 4) & 32'hFF);
            chk("dc_offset", 32'(bus.dc_offset), ea & 32'hF);
            chk("dc_wstrb", 32'(bus.dc_wstrb), op ? m_strb(size, ea) : 32'h0);
            chk("dc_wdata", bus.dc_wdata, op ? m_wdata(size, wdata) : 32'h0);
         end else begin
            chk("dc_valid_wait", 32'(bus.dc_valid), 32'h0);
         end
         if (k == rst_k) break;
      end
      @(negedge clk);
      bus.flush      = 1'b0;
      bus.dc_addr_ok = 1'b0;
      bus.dc_data_ok = 1'b0;
      rst            = 1'b1;
      #1;
      if (rst_k >= 0) begin
         chk("rst_dc_valid", 32'(bus.dc_valid), 32'h0);
      end else begin
         chk("resp_valid_after_data_ok", 32'(bus.resp_valid), 32'(flush_k < 0));
      end
      chk("req_ready_back_idle", 32'(bus.req_ready), 32'h1);
   endtask

   // A request presented together with flush in IDLE must not start anything.
   task automatic blocked_req();
      bus.req_valid = 1'b1;
      bus.flush     = 1'b1;
      bus.req_op    = 1'b0;
      bus.req_size  = 2'b10;
      bus.req_addr  = 32'h1C00_0010;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      #1;
      chk("flush_block_dc_valid", 32'(bus.dc_valid), 32'h0);
      chk("flush_block_req_ready", 32'(bus.req_ready), 32'h1);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: resp_valid=1 data 0x%08h, expected no response at %0t",
                        bus.resp_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("resp_data", bus.resp_data, e.data);
`ifdef LSU_MISALIGN_EXC_EN
               chk("misalign", 32'(bus.misalign), 32'(e.mis));
`endif
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int          op, size, sgn, a_lat, d_lat, flush_k, total;
      logic [31:0] addr;
      bus.req_valid  = 1'b0;
      bus.req_op     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.flush      = 1'b0;
      bus.dc_addr_ok = 1'b0;
      bus.dc_data_ok = 1'b0;
      bus.dc_rdata   = 32'h0;
      rst            = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("rst_dc_valid", 32'(bus.dc_valid), 32'h0);
      chk("rst_dc_op", 32'(bus.dc_op), 32'h0);
      chk("rst_dc_uncache", 32'(bus.dc_uncache), 32'h0);
      chk("rst_dc_wstrb", 32'(bus.dc_wstrb), 32'h0);
      chk("rst_dc_wdata", bus.dc_wdata, 32'h0);
      chk("rst_dc_tag", 32'(bus.dc_tag), 32'h0);
      chk("rst_resp_data", bus.resp_data, 32'h0);
`ifdef LSU_MISALIGN_EXC_EN
      chk("rst_misalign", 32'(bus.misalign), 32'h0);
`endif
      rst = 1'b1;

      // Signed byte load, data_ok three cycles after addr_ok.
      run_txn(1'b0, 0, 1'b1, 32'h1C00_0003, 32'h0, 32'h80FF_7F01, 0, 3, -1, -1);
      // Half store into the upper lanes.
      run_txn(1'b1, 1, 1'b0, 32'h1C00_0006, 32'h1234_ABCD, 32'h0, 1, 0, -1, -1);
      // Uncached word load with addr_ok delayed four cycles.
      run_txn(1'b0, 2, 1'b0, 32'hA000_1000, 32'h0, 32'h0BAD_F00D, 4, 1, -1, -1);
      // Flush while waiting for data, then an immediate follow-up request.
      run_txn(1'b0, 2, 1'b0, 32'h1C00_0020, 32'h0, 32'hDEAD_BEEF, 0, 3, 2, -1);
      run_txn(1'b0, 0, 1'b0, 32'h1C00_0041, 32'h0, 32'h1122_3344, 1, 1, -1, -1);
      // Misaligned word load.
      run_txn(1'b0, 2, 1'b0, 32'h1C00_0002, 32'h0, 32'hCAFE_F00D, 0, 1, -1, -1);
      // Unsigned half load from the upper half.
      run_txn(1'b0, 1, 1'b0, 32'h0000_00FE, 32'h0, 32'h8765_4321, 2, 2, -1, -1);
      // Reset while the dcache request is pending.
      run_txn(1'b1, 2, 1'b0, 32'h1C00_0100, 32'h0000_0055, 32'h0, 3, 0, -1, 1);
      blocked_req();

      for (int n = 0; n < 60; n++) begin
         op    = int'($urandom_range(0, 1));
         size  = int'($urandom_range(0, 3));
         sgn   = int'($urandom_range(0, 1));
         addr  = $urandom();
         if ($urandom_range(0, 3) == 0) addr[31:29] = 3'b101;
         a_lat = int'($urandom_range(0, 3));
         d_lat = int'($urandom_range(0, 3));
         total = a_lat + 1 + d_lat;
         flush_k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, total - 1)) : -1;
         run_txn(op[0], size, sgn[0], addr, $urandom(), $urandom(), a_lat, d_lat, flush_k, -1);
      end

      repeat (3) @(negedge clk);
      #3;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter UNCACHE_SEG, default 3'b101: req_addr[31:29] equal to this value marks the access uncached.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  memory op from the pipeline MEM stage is valid.
REQ-005 req_op  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-007 req_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-008 req_addr  in  32  byte address (physical, untranslated).
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 flush  in  1  pipeline flush.
REQ-011 req_ready  out  1  LSU accepts a request this cycle.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_data  out  32  extended load data; 0 for stores.
REQ-014 misalign  out  1  alignment fault; qualified by resp_valid; present only with LSU_MISALIGN_EXC_EN.
REQ-015 dc_valid, dc_op, dc_uncache  out  1 each  dcache request, op, uncache flag.
REQ-016 dc_index  out  8  addr[11:4]; dc_tag  out  20  addr[31:12]; dc_offset  out  4  addr[3:0].
REQ-017 dc_wstrb  out  4  byte enables; dc_wdata  out  32  lane-replicated store data.
REQ-018 dc_addr_ok, dc_data_ok  in  1 each  dcache handshakes; dc_rdata  in  32  dcache read data.

Function
REQ-019 States: IDLE, REQ, WAIT. req_ready is 1 only in IDLE.
- Acceptance: req_valid && req_ready && !flush at edge T.
- Accepted fields are registered and the FSM goes to REQ at T+1.
REQ-020 REQ: dc_valid=1 with all dc_* outputs driven from registers, held stable until dc_addr_ok.
- dc_addr_ok && dc_data_ok in the same cycle: go to IDLE.
- dc_addr_ok alone: go to WAIT.
- neither: stay in REQ.
REQ-021 WAIT: dc_valid=0. On dc_data_ok, go to IDLE.
REQ-022 resp_valid pulses in the cycle after dc_data_ok. resp_data is registered from dc_rdata at the data_ok edge.
REQ-023 Load extraction: byte from lane addr[1:0]; half from lane addr[1]; extend per req_signed.
REQ-024 Store strobes:
- byte: 4'b0001<<addr[1:0], wdata {4{b}}.
- half: 4'b0011<<{addr[1],1'b0}, wdata {2{h}}.
- word: 4'b1111.
Loads drive dc_wstrb=0 and dc_wdata=0.
REQ-025 flush while in IDLE blocks acceptance.
REQ-026 flush in REQ or WAIT sets a cancel flag:
- The dcache transaction still completes and dc_valid is never withdrawn.
- resp_valid is suppressed for that transaction.
- The flag clears on return to IDLE.
REQ-027 A new request is accepted no earlier than the cycle the FSM is in IDLE. There is no overlap or pipelining of requests.

Reset
REQ-028 With rst low at a posedge:
- FSM goes to IDLE and the cancel flag clears.
- req_ready=1; resp_valid, misalign, dc_valid, dc_op, dc_uncache, dc_wstrb are 0.
- All data/address registers are 0.
REQ-029 Reset mid-transaction abandons it silently, with no response.

Configuration
REQ-030 LSU_MISALIGN_EXC_EN defined:
- Misaligned word (addr[1:0]!=0) or half (addr[0]!=0) requests are accepted with no dcache access.
- The FSM stays in IDLE.
- Next cycle: resp_valid=1, misalign=1, resp_data=req_addr.
- If flush is asserted in that next cycle, the response is suppressed.
REQ-031 LSU_MISALIGN_EXC_EN undefined: the misalign port is absent; misaligned accesses use the address with the low bits forced aligned (word [1:0]=0, half [0]=0).

Structure
REQ-032 Package lsu_pkg holds the size encoding enum, the FSM state enum and the lsu_req_t struct (op, size, signed, addr, wdata).
REQ-033 One combinational sub-module, lsu_data_align, holds the strobe/data replication and the load extension logic.

Verification
REQ-034 Load byte signed, addr 0x1C000003, dc_rdata 0x80FF7F01, data_ok 3 cycles after addr_ok -> resp_data 0xFFFFFF80, one resp_valid pulse.
REQ-035 Store half, addr 0x1C000006, wdata 0x1234ABCD -> dc_wstrb 4'b1100, dc_wdata 0xABCDABCD, dc_tag 0x1C000, dc_index 0x00, dc_offset 0x6.
REQ-036 Load word, addr 0xA0001000, dc_addr_ok held low 4 cycles -> dc_uncache=1, dc_valid steady for 5 cycles, req_ready=0 throughout.
REQ-037 flush asserted in WAIT, then data_ok -> no resp_valid; the next request is accepted the cycle after returning to IDLE.
REQ-038 LSU_MISALIGN_EXC_EN defined, load word at 0x1C000002 -> dc_valid never asserted; misalign=1, resp_data=0x1C000002 one cycle after accept. Undefined -> dc_offset 0x0.
REQ-039 rst low while in REQ -> next cycle FSM in IDLE, dc_valid=0, no resp_valid.
